// File: rtl/sort_frame_packer.sv
// sort_frame_packer: groups a source stream into FRAME_LEN-element frames for the merge sorter.
// Optional build macro SORT_PAD_EN: complete short frames with all-ones pad elements.
module sort_frame_packer #(
    parameter int FRAME_LEN = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    input  logic              src_last,
    output logic              src_ready,
    output logic [DATA_W-1:0] out,
    output logic              valid_out,
    output logic              last_out,
    input  logic              ready,
    output logic              pad_active,
    output logic [15:0]       frame_count
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             load_ok;
    logic             src_take;
    logic             idx_end;

    // Output register can take a new beat when empty or being drained.
    assign load_ok   = !valid_out || ready;
    // Reset gating keeps src_ready low while rst_n is held.
    assign src_ready = rst_n && (state == FILL) && load_ok;
    assign src_take  = src_valid && src_ready;
    assign idx_end   = (idx == IDX_MAX);

`ifdef SORT_PAD_EN
    assign pad_active = (state == PAD);
`else
    assign pad_active = 1'b0;
`endif

    // Frame FSM, element index, output register and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            idx         <= '0;
            out         <= '0;
            valid_out   <= 1'b0;
            last_out    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (valid_out && ready) begin
                valid_out <= 1'b0;
                if (last_out) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
            unique case (state)
                FILL: begin
                    if (src_take) begin
                        out       <= src_data;
                        valid_out <= 1'b1;
                        if (idx_end) begin
                            last_out <= 1'b1;
                            idx      <= '0;
`ifdef SORT_PAD_EN
                        end else if (src_last) begin
                            last_out <= 1'b0;
                            idx      <= idx + IDX_ONE;
                            state    <= PAD;
`else
                        end else if (src_last) begin
                            last_out <= 1'b1;
                            idx      <= '0;
`endif
                        end else begin
                            last_out <= 1'b0;
                            idx      <= idx + IDX_ONE;
                        end
                    end
                end
`ifdef SORT_PAD_EN
                PAD: begin
                    if (load_ok) begin
                        out       <= '1;
                        valid_out <= 1'b1;
                        last_out  <= idx_end;
                        if (idx_end) begin
                            idx   <= '0;
                            state <= FILL;
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
`endif
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_frame_packer.sv
// Directed self-checking bench for sort_frame_packer.
// Expectations follow the SORT_PAD_EN setting of the build.
module tb_sort_frame_packer;

    localparam int FL = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] PADV = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] src_data;
    logic          src_valid;
    logic          src_last;
    logic          src_ready;
    logic [DW-1:0] out;
    logic          valid_out;
    logic          last_out;
    logic          ready;
    logic          pad_active;
    logic [15:0]   frame_count;

    sort_frame_packer #(.FRAME_LEN(FL), .DATA_W(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_last(src_last),
        .src_ready(src_ready),
        .out(out),
        .valid_out(valid_out),
        .last_out(last_out),
        .ready(ready),
        .pad_active(pad_active),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Beats the sorter will consume at the next rising edge.
    logic [DW-1:0] cap_d [0:1023];
    logic          cap_l [0:1023];
    int            cap_n = 0;

    always @(negedge clk) begin
        if (rst_n && valid_out && ready) begin
            if (cap_n < 1024) begin
                cap_d[cap_n] <= out;
                cap_l[cap_n] <= last_out;
            end
            cap_n <= cap_n + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_d [$];
    bit            exp_l [$];

    int            bp_bad;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic          held_v;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int  n;
        bit  acc;
        n = 0;
        src_valid = 1'b1;
        src_data  = d;
        src_last  = l;
        forever begin
            @(negedge clk);
            acc = src_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
    endtask

    task automatic drain(input int n, output int pads, output int bad);
        pads = 0;
        bad  = 0;
        repeat (n) begin
            @(negedge clk);
            if (pad_active) pads++;
            if (pad_active && src_ready) bad++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input int base);
        int bd;
        int bl;
        bd = 0;
        bl = 0;
        check({tag, "_beats"}, 64'(cap_n - base), 64'(exp_d.size()));
        foreach (exp_d[i]) begin
            if (base + i >= 1024 || cap_d[base + i] !== exp_d[i]) bd++;
            if (base + i >= 1024 || cap_l[base + i] !== exp_l[i]) bl++;
        end
        check({tag, "_data"}, 64'(bd), 64'd0);
        check({tag, "_last"}, 64'(bl), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pads;
        int bad;

        rst_n     = 1'b0;
        ready     = 1'b1;
        src_valid = 1'b1;
        src_data  = 32'd5;
        src_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", 64'(out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_last", 64'(last_out), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_pad_active", 64'(pad_active), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        src_valid = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;

        // Full frame 31..0, one-cycle latency.
        base = cap_n;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < FL; i++) begin
            exp_d.push_back(DW'(31 - i));
            exp_l.push_back(i == FL - 1);
        end
        check("t1_pre_valid", 64'(valid_out), 64'd0);
        send(32'd31, 1'b0);
        check("t1_lat_valid", 64'(valid_out), 64'd1);
        check("t1_lat_out", 64'(out), 64'd31);
        for (int i = 1; i < FL; i++) send(DW'(31 - i), 1'b0);
        drain(5, pads, bad);
        cmp("t1", base);
        check("t1_frame_count", 64'(frame_count), 64'd1);

        // Backpressure in mid-frame.
        base = cap_n;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < FL; i++) begin
            exp_d.push_back(DW'(100 + i));
            exp_l.push_back(i == FL - 1);
        end
        bp_bad = 0;
        fork
            for (int i = 0; i < FL; i++) send(DW'(100 + i), 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1;
                ready = 1'b0;
                @(negedge clk);
                held_d = out;
                held_l = last_out;
                held_v = valid_out;
                if (src_ready !== 1'b0) bp_bad++;
                repeat (4) begin
                    @(negedge clk);
                    if (src_ready !== 1'b0) bp_bad++;
                    if (out !== held_d || last_out !== held_l) bp_bad++;
                    if (valid_out !== 1'b1) bp_bad++;
                end
                @(posedge clk);
                #1;
                ready = 1'b1;
            end
        join
        check("t2_held_valid", 64'(held_v), 64'd1);
        check("t2_hold_stable", 64'(bp_bad), 64'd0);
        drain(5, pads, bad);
        cmp("t2", base);
        check("t2_frame_count", 64'(frame_count), 64'd2);

        // Short frame 7,2,9.
        base = cap_n;
        exp_d.delete();
        exp_l.delete();
        exp_d.push_back(32'd7);
        exp_d.push_back(32'd2);
        exp_d.push_back(32'd9);
`ifdef SORT_PAD_EN
        exp_l.push_back(1'b0);
        exp_l.push_back(1'b0);
        exp_l.push_back(1'b0);
        for (int i = 3; i < FL; i++) begin
            exp_d.push_back(PADV);
            exp_l.push_back(i == FL - 1);
        end
`else
        exp_l.push_back(1'b0);
        exp_l.push_back(1'b0);
        exp_l.push_back(1'b1);
`endif
        send(32'd7, 1'b0);
        send(32'd2, 1'b0);
        send(32'd9, 1'b1);
        drain(40, pads, bad);
        cmp("t3", base);
`ifdef SORT_PAD_EN
        check("t3_pad_cycles", 64'(pads), 64'd29);
`else
        check("t3_pad_cycles", 64'(pads), 64'd0);
`endif
        check("t3_src_ready_in_pad", 64'(bad), 64'd0);
        check("t3_frame_count", 64'(frame_count), 64'd3);

        // src_last on the final index: no pads.
        base = cap_n;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < FL; i++) begin
            exp_d.push_back(DW'(500 + i));
            exp_l.push_back(i == FL - 1);
        end
        for (int i = 0; i < FL; i++) send(DW'(500 + i), i == FL - 1);
        drain(5, pads, bad);
        cmp("t4", base);
        check("t4_pad_cycles", 64'(pads), 64'd0);
        check("t4_frame_count", 64'(frame_count), 64'd4);

        // src_last on index 0.
        base = cap_n;
        exp_d.delete();
        exp_l.delete();
        exp_d.push_back(32'd77);
`ifdef SORT_PAD_EN
        exp_l.push_back(1'b0);
        for (int i = 1; i < FL; i++) begin
            exp_d.push_back(PADV);
            exp_l.push_back(i == FL - 1);
        end
`else
        exp_l.push_back(1'b1);
`endif
        send(32'd77, 1'b1);
        drain(40, pads, bad);
        cmp("t5", base);
`ifdef SORT_PAD_EN
        check("t5_pad_cycles", 64'(pads), 64'd31);
`else
        check("t5_pad_cycles", 64'(pads), 64'd0);
`endif
        check("t5_frame_count", 64'(frame_count), 64'd5);

        // Reset in the middle of a frame with a held beat.
        for (int i = 0; i < 10; i++) send(DW'(i), 1'b0);
        ready = 1'b0;
        #2;
        check("t6_pre_valid", 64'(valid_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", 64'(out), 64'd0);
        check("t6_rst_valid", 64'(valid_out), 64'd0);
        check("t6_rst_last", 64'(last_out), 64'd0);
        check("t6_rst_src_ready", 64'(src_ready), 64'd0);
        check("t6_rst_frame_count", 64'(frame_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        base = cap_n;
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < FL; i++) begin
            exp_d.push_back(DW'(31 - i));
            exp_l.push_back(i == FL - 1);
        end
        for (int i = 0; i < FL; i++) send(DW'(31 - i), 1'b0);
        drain(5, pads, bad);
        cmp("t6", base);
        check("t6_frame_count", 64'(frame_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sort_frame_packer.md
# sort_frame_packer

Input framing stage that feeds the 32-element streaming merge sorter (`top`): accepts a free-running source stream with valid/ready flow control and a short-frame marker, groups it into fixed frames of FRAME_LEN elements, and drives the sorter's `in`/`valid_in`/`last_in` while honouring its `ready`. Short frames are completed with maximum-value pad elements so the sorter always sees complete frames; pads sort to the tail of each ascending output frame.

## Interface
- FRAME_LEN, 32: elements per frame; must equal the sorter depth; power of two, 2..256.
- DATA_W, `DATA_W` from def.h: element width.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- src_data  in  DATA_W  source element.
- src_valid  in  1  src_data valid.
- src_last  in  1  qualifies src_data as final element of a (possibly short) frame.
- src_ready  out  1  packer accepts a source beat this cycle.
- out  out  DATA_W  element to sorter `in`.
- valid_out  out  1  to sorter `valid_in`.
- last_out  out  1  to sorter `last_in`; high on element FRAME_LEN-1 of a frame.
- ready  in  1  from sorter `ready`; sorter consumes a beat in any cycle with valid_out && ready.
- pad_active  out  1  packer is in PAD state.
- frame_count  out  16  completed frames transferred to sorter, wraps 65535 -> 0.

## Operation
- Single output register (out, valid_out, last_out); registered outputs only.
- Source accept: src_valid && src_ready; src_ready = (state == FILL) && (!valid_out || ready).
- Element index idx, clog2(FRAME_LEN) bits, 0 at frame start; incremented on each beat loaded into the output register (source or pad).
- last_out loaded as (idx == FRAME_LEN-1).
- States: FILL (pass source beats), PAD (generate pads; `PAD_EN` builds only).
- FILL: accepted beat loaded; if idx == FRAME_LEN-1 -> idx := 0, stay FILL (src_last ignored here). Else if src_last -> PAD (PAD_EN) with idx+1; else idx+1.
- PAD: src_ready = 0; whenever output register free or being consumed, load out = all-ones ({DATA_W{1'b1}}); last on idx == FRAME_LEN-1, then idx := 0 and -> FILL.
- frame_count increments in the cycle a beat with last_out is consumed (valid_out && ready && last_out).
- Held beat: while valid_out && !ready, out/last_out stable, no new load.

## Timing
- Reset values: out = 0, valid_out = 0, last_out = 0, src_ready = 0 during reset, pad_active = 0, frame_count = 0, idx = 0, state FILL.
- Latency: source accept at edge N -> valid_out at N+1.
- Throughput: 1 beat/cycle when ready held high; no bubble FILL->PAD or PAD->FILL.
- src_ready depends combinationally on ready (pass-through).
- src_last on idx 0: FRAME_LEN-1 pads follow. src_last on idx FRAME_LEN-1: no pads.
- pad_active asserted from the cycle after the src_last accept to the cycle the final pad is loaded, inclusive.
- Reset asserted mid-frame: immediate clear of all state; partial frame discarded; first beat after release is idx 0.

## Configuration
- `SORT_PAD_EN` defined: PAD state present; short frames padded to FRAME_LEN with all-ones, last_out only on idx FRAME_LEN-1.
- `SORT_PAD_EN` undefined: no PAD state, pad_active tied 0; src_last beat loaded with last_out = 1 and idx := 0 (short frame passed to sorter as-is); frame_count counts short frames too.

## Test plan
- Reset: rst_n low mid-stream -> all outputs 0 same cycle, frame_count 0; after release, 32 beats 31..0 -> out 31..0 at 1-cycle latency, last_out only on 32nd, frame_count 1.
- Backpressure: ready low cycles 5-9 of a frame, src_valid held high -> out/last_out frozen, src_ready low, no beat lost or duplicated, 32 beats total.
- Short frame (SORT_PAD_EN): 3 beats 7,2,9 with src_last on 9 -> out 7,2,9 then 29 x 0xFF..F, last_out on final pad, src_ready low during pads, pad_active high 29 cycles.
- Short frame (no macro): same stimulus -> out 7,2,9, last_out on 9, next beat idx 0, frame_count 1.
- Boundary: src_last on idx 31 -> no pads; src_last on idx 0 -> 31 pads.
- Wrap: 65536 full frames -> frame_count returns to 0.
